// File: rtl/la_capture_display.sv
// Logic-analyzer core: edge-triggered circular capture with pre-trigger history,
// rendered as per-channel waveform lanes. Optional trigger cursor: LA_TRIG_CURSOR_EN.
module la_capture_display #(
    parameter int          CHANNEL_COUNT   = 10,
    parameter int          SAMPLE_DEPTH    = 640,
    parameter int          PRETRIG         = 64,
    parameter int          SAMPLE_DIV      = 1,
    parameter int          HEADER_ROWS     = 64,
    parameter int          LANE_HEIGHT     = 40,
    parameter int          VGA_COLOR_DEPTH = 4,
    parameter logic [23:0] BG_COLOR        = 24'h000000,
    parameter logic [23:0] SIG_COLOR       = 24'h00FF00,
    parameter logic [23:0] CURSOR_COLOR    = 24'hFF0000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CHANNEL_COUNT-1:0]             probe,
    input  logic [CHANNEL_COUNT-1:0]             chan_enable,
    input  logic                                 arm,
    input  logic [$clog2(CHANNEL_COUNT)-1:0]     trig_chan,
    input  logic                                 trig_falling,
    input  logic [11:0]                          display_col,
    input  logic [10:0]                          display_row,
    input  logic                                 visible,
    output logic [VGA_COLOR_DEPTH-1:0]           vga_r,
    output logic [VGA_COLOR_DEPTH-1:0]           vga_g,
    output logic [VGA_COLOR_DEPTH-1:0]           vga_b,
    output logic                                 busy,
    output logic                                 capture_done
);
    localparam int AW   = (SAMPLE_DEPTH > 1) ? $clog2(SAMPLE_DEPTH) : 1;
    localparam int DW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TCW  = $clog2(CHANNEL_COUNT);
    localparam int YW   = $clog2(LANE_HEIGHT);
    localparam int POST = SAMPLE_DEPTH - PRETRIG - 1;
    localparam int CD   = VGA_COLOR_DEPTH;

    localparam logic [3*CD-1:0] BG_PIX  = {BG_COLOR[23 -: CD], BG_COLOR[15 -: CD], BG_COLOR[7 -: CD]};
    localparam logic [3*CD-1:0] SIG_PIX = {SIG_COLOR[23 -: CD], SIG_COLOR[15 -: CD], SIG_COLOR[7 -: CD]};
`ifdef LA_TRIG_CURSOR_EN
    localparam logic [3*CD-1:0] CUR_PIX = {CURSOR_COLOR[23 -: CD], CURSOR_COLOR[15 -: CD], CURSOR_COLOR[7 -: CD]};
`endif

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIGGERED, S_DONE} state_t;

    state_t                   state_q;
    logic [DW-1:0]            div_q;
    logic [AW-1:0]            wptr_q, pre_cnt_q, post_cnt_q, start_q;
    logic                     have_prev_q, trig_prev_q, busy_q, done_q;
    logic [CHANNEL_COUNT-1:0] mem [SAMPLE_DEPTH];
    logic [CHANNEL_COUNT-1:0] rd_q, col_prev_q;

    logic          tick, trig_bit, chan_ok, edge_hit, trig_ok, wr_en;
    logic [AW-1:0] wptr_d, start_d;
    logic [AW:0]   start_sum;

    always_comb begin
        tick     = (div_q == DW'(SAMPLE_DIV - 1));
        trig_bit = 1'b0;
        chan_ok  = 1'b0;
        for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (trig_chan == TCW'(i)) begin
                trig_bit = probe[i];
                chan_ok  = 1'b1;
            end
        end
        edge_hit  = have_prev_q && chan_ok &&
                    (trig_falling ? (trig_prev_q && !trig_bit) : (!trig_prev_q && trig_bit));
        trig_ok   = edge_hit && (pre_cnt_q >= AW'(PRETRIG));
        wptr_d    = (wptr_q == AW'(SAMPLE_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        start_sum = {1'b0, wptr_q} + (AW+1)'(SAMPLE_DEPTH - PRETRIG);
        start_d   = (start_sum >= (AW+1)'(SAMPLE_DEPTH)) ? AW'(start_sum - (AW+1)'(SAMPLE_DEPTH))
                                                         : AW'(start_sum);
        wr_en     = !reset && !arm && tick && (state_q == S_ARMED || state_q == S_TRIGGERED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            wptr_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            start_q     <= '0;
            have_prev_q <= 1'b0;
            trig_prev_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // status flags follow the state register one cycle later
            busy_q <= (state_q == S_ARMED) || (state_q == S_TRIGGERED);
            done_q <= (state_q == S_DONE);
            div_q  <= tick ? '0 : div_q + 1'b1;
            if (arm) begin
                state_q     <= S_ARMED;
                div_q       <= '0;
                wptr_q      <= '0;
                pre_cnt_q   <= '0;
                post_cnt_q  <= '0;
                have_prev_q <= 1'b0;
            end else if (tick) begin
                case (state_q)
                    S_ARMED: begin
                        wptr_q      <= wptr_d;
                        have_prev_q <= 1'b1;
                        trig_prev_q <= trig_bit;
                        if (pre_cnt_q < AW'(PRETRIG)) pre_cnt_q <= pre_cnt_q + 1'b1;
                        if (trig_ok) begin
                            start_q    <= start_d;
                            post_cnt_q <= '0;
                            state_q    <= (POST == 0) ? S_DONE : S_TRIGGERED;
                        end
                    end
                    S_TRIGGERED: begin
                        wptr_q     <= wptr_d;
                        post_cnt_q <= post_cnt_q + 1'b1;
                        if (post_cnt_q == AW'(POST - 1)) state_q <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Render stage 1: lane decode via range compares, memory read issue
    logic [10:0]              rel;
    logic [CHANNEL_COUNT-1:0] lane_oh;
    logic [YW-1:0]            y;
    logic                     col_ok, lane_ok;
    logic [AW:0]              rsum;
    logic [AW-1:0]            raddr;

    always_comb begin
        rel     = display_row - 11'(HEADER_ROWS);
        lane_oh = '0;
        y       = '0;
        for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (rel >= 11'(i * LANE_HEIGHT) && rel < 11'((i + 1) * LANE_HEIGHT)) begin
                lane_oh[i] = 1'b1;
                y          = YW'(rel - 11'(i * LANE_HEIGHT));
            end
        end
        col_ok  = (display_col < 12'(SAMPLE_DEPTH));
        lane_ok = (display_row >= 11'(HEADER_ROWS)) && |(lane_oh & chan_enable) &&
                  col_ok && (state_q == S_DONE);
        rsum    = {1'b0, start_q} + (AW+1)'(display_col);
        if (!col_ok)
            raddr = '0;
        else if (rsum >= (AW+1)'(SAMPLE_DEPTH))
            raddr = AW'(rsum - (AW+1)'(SAMPLE_DEPTH));
        else
            raddr = AW'(rsum);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= probe;
        rd_q <= mem[raddr];
    end

    logic                     p1_vis_q, p1_hit_q, p1_col0_q, p1_colok_q;
    logic [CHANNEL_COUNT-1:0] p1_oh_q;
    logic [YW-1:0]            p1_y_q;
`ifdef LA_TRIG_CURSOR_EN
    logic                     p1_cur_q;
`endif
    logic [3*CD-1:0]          pix_d, pix_q;
    logic                     s_cur, s_prev, line_hit, seg_hit;

    always_comb begin
        s_cur    = |(rd_q & p1_oh_q);
        s_prev   = |(col_prev_q & p1_oh_q);
        line_hit = (p1_y_q == YW'(4) && s_cur) || (p1_y_q == YW'(LANE_HEIGHT - 5) && !s_cur);
        seg_hit  = !p1_col0_q && (s_cur != s_prev) &&
                   (p1_y_q >= YW'(4)) && (p1_y_q <= YW'(LANE_HEIGHT - 5));
        pix_d    = BG_PIX;
        if (p1_hit_q && (line_hit || seg_hit))
            pix_d = SIG_PIX;
`ifdef LA_TRIG_CURSOR_EN
        else if (p1_hit_q && p1_cur_q)
            pix_d = CUR_PIX;
`endif
        if (!p1_vis_q) pix_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vis_q   <= 1'b0;
            p1_hit_q   <= 1'b0;
            p1_col0_q  <= 1'b0;
            p1_colok_q <= 1'b0;
            p1_oh_q    <= '0;
            p1_y_q     <= '0;
`ifdef LA_TRIG_CURSOR_EN
            p1_cur_q   <= 1'b0;
`endif
            col_prev_q <= '0;
            pix_q      <= '0;
        end else begin
            p1_vis_q   <= visible;
            p1_hit_q   <= lane_ok;
            p1_col0_q  <= (display_col == 12'd0);
            p1_colok_q <= col_ok;
            p1_oh_q    <= lane_oh;
            p1_y_q     <= y;
`ifdef LA_TRIG_CURSOR_EN
            p1_cur_q   <= (display_col == 12'(PRETRIG));
`endif
            if (p1_colok_q) col_prev_q <= rd_q;
            pix_q      <= pix_d;
        end
    end

    assign vga_r        = pix_q[3*CD-1 -: CD];
    assign vga_g        = pix_q[2*CD-1 -: CD];
    assign vga_b        = pix_q[CD-1 -: CD];
    assign busy         = busy_q;
    assign capture_done = done_q;
endmodule

// File: tb/tb_la_capture_display.sv
// Bench for la_capture_display: two instances (1 and 3 clocks per sample) checked
// against a queue-based capture model and a divide/modulo lane renderer.
module tb_la_capture_display;
    localparam int CH = 5, DEPTH = 16, PRE = 4, HR = 8, LH = 20, CD = 4;
    localparam int POST = DEPTH - PRE - 1;
    localparam logic [23:0] BG = 24'h000000, SIG = 24'h00FF00, CUR = 24'hFF0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, arm1, arm3, tfall1, tfall3, vis;
    logic [CH-1:0] probe, chan_enable;
    logic [2:0]    tchan1, tchan3;
    logic [11:0]   col;
    logic [10:0]   row;
    logic [CD-1:0] r1, g1, b1, r3, g3, b3;
    logic          busy1, done1, busy3, done3;

    la_capture_display #(.CHANNEL_COUNT(CH), .SAMPLE_DEPTH(DEPTH), .PRETRIG(PRE), .SAMPLE_DIV(1),
        .HEADER_ROWS(HR), .LANE_HEIGHT(LH), .VGA_COLOR_DEPTH(CD), .BG_COLOR(BG),
        .SIG_COLOR(SIG), .CURSOR_COLOR(CUR)) dut1 (
        .clk(clk), .reset(reset), .probe(probe), .chan_enable(chan_enable), .arm(arm1),
        .trig_chan(tchan1), .trig_falling(tfall1), .display_col(col), .display_row(row),
        .visible(vis), .vga_r(r1), .vga_g(g1), .vga_b(b1), .busy(busy1), .capture_done(done1));

    la_capture_display #(.CHANNEL_COUNT(CH), .SAMPLE_DEPTH(DEPTH), .PRETRIG(PRE), .SAMPLE_DIV(3),
        .HEADER_ROWS(HR), .LANE_HEIGHT(LH), .VGA_COLOR_DEPTH(CD), .BG_COLOR(BG),
        .SIG_COLOR(SIG), .CURSOR_COLOR(CUR)) dut3 (
        .clk(clk), .reset(reset), .probe(probe), .chan_enable(chan_enable), .arm(arm3),
        .trig_chan(tchan3), .trig_falling(tfall3), .display_col(col), .display_row(row),
        .visible(vis), .vga_r(r3), .vga_g(g3), .vga_b(b3), .busy(busy3), .capture_done(done3));

    int errors = 0, checks = 0;
    logic [CH-1:0] mcap [2][DEPTH];
    bit            mdone [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*CD-1:0] pk(input logic [23:0] c);
        return {c[23 -: CD], c[15 -: CD], c[7 -: CD]};
    endfunction

    function automatic logic [3*CD-1:0] exp_pix(input int which, input int c, input int rw, input bit v);
        int lane, y;
        bit s, sp, sig;
        logic [CH-1:0] cur, prv;
        if (!v) return '0;
        if (!mdone[which] || rw < HR || c >= DEPTH) return pk(BG);
        lane = (rw - HR) / LH;
        y    = (rw - HR) % LH;
        if (lane >= CH) return pk(BG);
        if (!chan_enable[lane]) return pk(BG);
        cur = mcap[which][c];
        s   = cur[lane];
        sig = (y == 4 && s) || (y == LH - 5 && !s);
        if (c > 0) begin
            prv = mcap[which][c-1];
            sp  = prv[lane];
            if (y >= 4 && y <= LH - 5 && sp != s) sig = 1'b1;
        end
        if (sig) return pk(SIG);
`ifdef LA_TRIG_CURSOR_EN
        if (c == PRE) return pk(CUR);
`endif
        return pk(BG);
    endfunction

    // mode 0: counter with ch0 = 0,0,1,0,1 prefix; mode 1: glitch then forced edge; mode 2: random
    task automatic capture(input int which, input logic [2:0] tch, input bit fall,
                           input int ncyc, input int mode);
        logic [CH-1:0] pv[$], tv[$], a, b;
        int tcyc[$];
        int div, k, dedge, m;
        logic [4:0] pat;
        logic [CH-1:0] v;
        bit edge_seen;
        div = (which == 0) ? 1 : 3;
        pat = 5'b10100;
        for (int n = 0; n < ncyc; n++) begin
            v = CH'($urandom);
            if (mode == 0) begin
                v = CH'(n);
                if (n < 5) v[0] = pat[n];
            end else if (mode == 1) begin
                if (n < 12) v[0] = (n == 4);
                else if (n < 18) v[0] = 1'b1;
            end
            pv.push_back(v);
            if (n % div == div - 1) begin
                tcyc.push_back(n);
                tv.push_back(v);
            end
        end
        k = -1;
        for (int j = 1; j < tv.size(); j++) begin
            a = tv[j-1];
            b = tv[j];
            edge_seen = (tch < CH) && (fall ? (a[tch] && !b[tch]) : (!a[tch] && b[tch]));
            if (edge_seen && j >= PRE) begin
                k = j;
                break;
            end
        end
        dedge = -1;
        if (k >= 0 && k + POST < tv.size()) dedge = tcyc[k + POST] + 1;
        mdone[which] = (dedge >= 0);
        if (dedge >= 0)
            for (int j = 0; j < DEPTH; j++) mcap[which][j] = tv[k - PRE + j];

        if (which == 0) begin arm1 = 1'b1; tchan1 = tch; tfall1 = fall; end
        else            begin arm3 = 1'b1; tchan3 = tch; tfall3 = fall; end
        @(posedge clk); #1;
        arm1 = 1'b0;
        arm3 = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            probe = pv[n];
            @(posedge clk); #1;
            m = n + 1;
            check("busy", (which == 0) ? busy1 : busy3, (dedge < 0) ? 1 : (m <= dedge));
            check("capture_done", (which == 0) ? done1 : done3, (dedge >= 0) && (m >= dedge + 1));
        end
    endtask

    task automatic render(input int which, input logic [CH-1:0] en);
        int rows[] = '{3, 8, 12, 18, 23, 27, 32, 38, 43, 52, 58, 63, 72, 78, 83, 92, 98, 103, 107, 108, 120};
        logic [3*CD-1:0] q[$], e, pix;
        chan_enable = en;
        foreach (rows[ri]) begin
            for (int c = 0; c < DEPTH + 2; c++) begin
                col = 12'(c);
                row = 11'(rows[ri]);
                vis = ($urandom_range(7) != 0);
                q.push_back(exp_pix(which, c, rows[ri], vis));
                @(posedge clk); #1;
                if (q.size() == 2) begin
                    e   = q.pop_front();
                    pix = (which == 0) ? {r1, g1, b1} : {r3, g3, b3};
                    check("pixel", pix, e);
                end
            end
        end
        vis = 1'b0;
        @(posedge clk); #1;
        e   = q.pop_front();
        pix = (which == 0) ? {r1, g1, b1} : {r3, g3, b3};
        check("pixel_last", pix, e);
    endtask

    initial begin
        reset = 1'b1; arm1 = 1'b1; arm3 = 1'b0; probe = '0; chan_enable = '1;
        tchan1 = '0; tchan3 = '0; tfall1 = 1'b0; tfall3 = 1'b0;
        col = '0; row = '0; vis = 1'b0;
        mdone[0] = 1'b0; mdone[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_busy3", busy3, 0);
        check("rst_done3", done3, 0);
        check("rst_pix1", {r1, g1, b1}, 0);
        check("rst_pix3", {r3, g3, b3}, 0);
        reset = 1'b0; arm1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("arm_vs_reset_busy", busy1, 0);

        capture(0, 3'd0, 1'b0, 24, 0);
        render(0, 5'b11101);
        capture(1, 3'd0, 1'b0, 60, 1);
        render(1, 5'b11101);
        capture(1, 3'($urandom_range(CH - 1)), 1'b1, 120, 2);
        render(1, CH'($urandom));
        capture(0, 3'd6, 1'b0, 40, 2);
        render(0, '1);

        capture(0, 3'd0, 1'b0, 8, 0);
        capture(0, 3'd0, 1'b0, 3, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mdone[0] = 1'b0;
        @(posedge clk); #1;
        check("midcap_rst_busy", busy1, 0);
        check("midcap_rst_done", done1, 0);
        render(0, '1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
